// File: rtl/noc_params_pkg.sv
// Shared NoC definitions: flit types, flit record, default payload width and
// the packet-tracking FSM states used by the input request unit.
package noc_params;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_type_t;

    typedef struct packed {
        flit_type_t              ftype;
        logic [DATA_WIDTH-1:0]   payload;
    } flit_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // HEAD and HEADTAIL both open a packet.
    function automatic logic is_head(input flit_type_t t);
        return (t == HEAD) || (t == HEADTAIL);
    endfunction

endpackage

// File: rtl/circular_buffer.sv
// Circular FIFO holding upstream flits.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   i_push        write i_wdata at tail (ignored when full)
//   i_pop         drop head entry (ignored when empty)
//   i_wdata       entry to write
//   o_full        DEPTH entries stored
//   o_empty       no entries stored
//   o_rdata       head-of-queue entry (valid while !o_empty)
module circular_buffer #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 34
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_rdata
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_rdata = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: contents are only observed through the count.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/input_request_unit.sv
// NoC input request unit: buffers upstream flits, requests the round-robin
// arbiter when a flit and a downstream credit are available, forwards granted
// flits with one cycle of latency and holds the arbiter lock for a packet.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   data_i       upstream flit; valid_i qualifies it; ready_o = FIFO not full
//   request_o    arbiter request; grant_i same-cycle grant bit
//   lock_o       packet in progress
//   credit_i     one downstream slot returned
//   data_o       forwarded flit; valid_o qualifies it
//   error_o      single-cycle protocol violation pulse
module input_request_unit
    import noc_params::*;
#(
    parameter int BUFFER_SIZE = 8,
    parameter int MAX_CREDITS = 4,
    parameter int DATA_WIDTH  = noc_params::DATA_WIDTH
) (
    input  logic  clk,
    input  logic  rst,
    input  flit_t data_i,
    input  logic  valid_i,
    output logic  ready_o,
    output logic  request_o,
    input  logic  grant_i,
    output logic  lock_o,
    input  logic  credit_i,
    output flit_t data_o,
    output logic  valid_o,
    output logic  error_o
);

    localparam int CW = $clog2(MAX_CREDITS + 1);
    localparam int FW = 2 + DATA_WIDTH;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_credits;
    flit_t         r_data_o;
    logic          r_valid_o;

    logic [FW-1:0] w_push_data;
    logic [FW-1:0] w_rd_data;
    flit_t         w_head;
    logic          w_full;
    logic          w_empty;
    logic          w_discard;
    logic          w_request;
    logic          w_xfer;
    logic          w_credit_max;
    logic          w_credit_ovf;

    assign w_push_data = data_i;
    assign w_head      = w_rd_data;

    circular_buffer #(
        .DEPTH (BUFFER_SIZE),
        .WIDTH (FW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (valid_i),
        .i_pop   (w_xfer || w_discard),
        .i_wdata (w_push_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_rdata (w_rd_data)
    );

    // A BODY/TAIL with no open packet is dropped without touching the arbiter.
    assign w_discard    = (r_state == IDLE) && !w_empty && !is_head(w_head.ftype);
    assign w_request    = !w_empty && (r_credits != '0) && !w_discard;
    assign w_xfer       = w_request && grant_i;
    assign w_credit_max = (r_credits == CW'(MAX_CREDITS));
    assign w_credit_ovf = credit_i && !w_xfer && w_credit_max;

    assign ready_o   = !w_full;
    assign request_o = w_request;
    assign data_o    = r_data_o;
    assign valid_o   = r_valid_o;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_credits <= CW'(MAX_CREDITS);
        end else if (w_xfer && !credit_i) begin
            r_credits <= r_credits - 1'b1;
        end else if (credit_i && !w_xfer && !w_credit_max) begin
            r_credits <= r_credits + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data_o  <= '0;
            r_valid_o <= 1'b0;
        end else begin
            r_valid_o <= w_xfer;
            if (w_xfer) r_data_o <= w_head;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // FSM: next state, driven purely by the type of the transferred flit
    always_comb begin
        w_next = r_state;
        if (w_xfer) begin
            case (w_head.ftype)
                HEAD:     w_next = ACTIVE;
                TAIL:     w_next = IDLE;
                HEADTAIL: w_next = IDLE;
                default:  w_next = r_state;
            endcase
        end
    end

    // FSM: outputs. error_o is masked during reset so a stray credit_i
    // cannot pulse it while state is held.
    always_comb begin
        lock_o  = (r_state == ACTIVE);
        error_o = rst && (w_discard || w_credit_ovf ||
                  (w_xfer && (r_state == ACTIVE) && is_head(w_head.ftype)));
    end

endmodule

// File: tb/tb_input_request_unit.sv
module tb_input_request_unit;
    import noc_params::*;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    flit_t data_i;
    logic  valid_i, ready_o, request_o, grant_i, lock_o, credit_i, valid_o, error_o;
    flit_t data_o;

    always #5 clk = ~clk;

    input_request_unit #(
        .BUFFER_SIZE (8),
        .MAX_CREDITS (4),
        .DATA_WIDTH  (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_i    (data_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .request_o (request_o),
        .grant_i   (grant_i),
        .lock_o    (lock_o),
        .credit_i  (credit_i),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .error_o   (error_o)
    );

    int    n_cmp = 0;
    int    n_bad = 0;
    int    n_fwd = 0;
    int    pay   = 0;
    int    base;
    flit_t exp_q[$];
    flit_t mon_f;

    typedef struct {
        flit_type_t ft;
        bit         fwd;
        bit         err;
        bit         lock;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: every valid_o must match the oldest expected flit.
    always @(negedge clk) begin
        if (rst && valid_o) begin
            n_fwd++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_valid_o: got flit %0h expected none (t=%0t)", data_o, $time);
            end else begin
                mon_f = exp_q.pop_front();
                chk("data_o", data_o, mon_f);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    function automatic flit_t mkf(input flit_type_t t);
        flit_t f;
        f.ftype   = t;
        f.payload = 32'hA000_0000 + 32'(pay);
        pay++;
        return f;
    endfunction

    // Present one flit for one cycle; optionally expect it downstream.
    task automatic push(input flit_type_t t, input bit fwd);
        flit_t f;
        f       = mkf(t);
        data_i  = f;
        valid_i = 1'b1;
        if (fwd) exp_q.push_back(f);
        step();
        valid_i = 1'b0;
    endtask

    task automatic do_reset();
        repeat (3) step();
        smp();
        chk("queue_drained", 64'(exp_q.size()), 0);
        step();
        rst      = 1'b0;
        valid_i  = 1'b0;
        grant_i  = 1'b0;
        credit_i = 1'b0;
        step();
        step();
        exp_q.delete();
        rst = 1'b1;
    endtask

    initial begin
        // ft, fwd, err, lock-after; walks IDLE/ACTIVE through every type
        tbl[0] = '{HEADTAIL, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{BODY,     1'b0, 1'b1, 1'b0};
        tbl[2] = '{HEAD,     1'b1, 1'b0, 1'b1};
        tbl[3] = '{BODY,     1'b1, 1'b0, 1'b1};
        tbl[4] = '{HEAD,     1'b1, 1'b1, 1'b1};
        tbl[5] = '{HEADTAIL, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{TAIL,     1'b0, 1'b1, 1'b0};
        tbl[7] = '{HEAD,     1'b1, 1'b0, 1'b1};
        tbl[8] = '{TAIL,     1'b1, 1'b0, 1'b0};

        data_i   = '0;
        valid_i  = 1'b0;
        grant_i  = 1'b0;
        credit_i = 1'b1;
        step();
        smp();
        chk("rst_ready",   64'(ready_o),   1);
        chk("rst_request", 64'(request_o), 0);
        chk("rst_lock",    64'(lock_o),    0);
        chk("rst_valid",   64'(valid_o),   0);
        chk("rst_error",   64'(error_o),   0);
        chk("rst_data",    64'(data_o),    0);
        step();
        credit_i = 1'b0;
        rst      = 1'b1;

        // Table: single flits with grant held high, credit returned after each
        grant_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            push(tbl[i].ft, tbl[i].fwd);
            smp();
            chk($sformatf("tbl%0d_request", i), 64'(request_o), 64'(tbl[i].fwd));
            chk($sformatf("tbl%0d_error", i),   64'(error_o),   64'(tbl[i].err));
            step();
            smp();
            chk($sformatf("tbl%0d_lock", i), 64'(lock_o), 64'(tbl[i].lock));
            chk($sformatf("tbl%0d_err_clr", i), 64'(error_o), 0);
            if (tbl[i].fwd) begin
                step();
                credit_i = 1'b1;
                smp();
                chk($sformatf("tbl%0d_credit_err", i), 64'(error_o), 0);
                step();
                credit_i = 1'b0;
            end
        end
        // Discards consumed no credit: four flits go, the fifth waits
        for (int k = 0; k < 4; k++) begin
            push(HEADTAIL, 1'b1);
            smp();
            chk("disc_credit_req", 64'(request_o), 1);
            step();
        end
        push(HEADTAIL, 1'b1);
        smp();
        chk("disc_credit_exhaust", 64'(request_o), 0);
        step();
        credit_i = 1'b1;
        step();
        credit_i = 1'b0;
        do_reset();

        // HEAD, BODY, TAIL back-to-back with grant tied high
        grant_i = 1'b1;
        data_i  = mkf(HEAD);  exp_q.push_back(data_i);  valid_i = 1'b1;
        step();
        data_i  = mkf(BODY);  exp_q.push_back(data_i);
        smp();
        chk("hbt_req", 64'(request_o), 1);
        step();
        data_i  = mkf(TAIL);  exp_q.push_back(data_i);
        smp();
        chk("hbt_v1", 64'(valid_o), 1);
        chk("hbt_l1", 64'(lock_o),  1);
        step();
        valid_i = 1'b0;
        smp();
        chk("hbt_v2", 64'(valid_o), 1);
        chk("hbt_l2", 64'(lock_o),  1);
        step();
        smp();
        chk("hbt_v3", 64'(valid_o), 1);
        chk("hbt_l3", 64'(lock_o),  0);
        step();
        smp();
        chk("hbt_v4", 64'(valid_o), 0);
        // one credit left, then none
        push(HEADTAIL, 1'b1);
        smp();
        chk("hbt_last_credit", 64'(request_o), 1);
        step();
        push(HEADTAIL, 1'b1);
        smp();
        chk("hbt_no_credit", 64'(request_o), 0);
        step();
        credit_i = 1'b1;
        step();
        credit_i = 1'b0;
        smp();
        chk("hbt_credit_back", 64'(request_o), 1);
        do_reset();

        // 6-flit packet against 4 credits
        push(HEAD, 1'b1);
        for (int k = 0; k < 4; k++) push(BODY, 1'b1);
        push(TAIL, 1'b1);
        base    = n_fwd;
        grant_i = 1'b1;
        repeat (8) step();
        smp();
        chk("cr_fwd4",  64'(n_fwd - base), 4);
        chk("cr_req0",  64'(request_o),   0);
        chk("cr_lock",  64'(lock_o),      1);
        step();
        credit_i = 1'b1;
        step();
        credit_i = 1'b0;
        repeat (3) step();
        credit_i = 1'b1;
        step();
        credit_i = 1'b0;
        repeat (4) step();
        smp();
        chk("cr_fwd6", 64'(n_fwd - base), 6);
        chk("cr_unlock", 64'(lock_o), 0);
        do_reset();

        // Fill the FIFO: 9 back-to-back flits, depth 8
        for (int i = 0; i < 9; i++) begin
            data_i  = mkf((i == 0) ? HEAD : BODY);
            valid_i = 1'b1;
            if (i < 8) exp_q.push_back(data_i);
            step();
            chk($sformatf("full_ready%0d", i), 64'(ready_o), 64'(i < 7));
        end
        valid_i = 1'b0;
        base    = n_fwd;
        grant_i = 1'b1;
        step();
        grant_i = 1'b0;
        chk("full_ready_after_pop", 64'(ready_o), 1);
        grant_i = 1'b1;
        repeat (4) step();
        repeat (4) begin
            credit_i = 1'b1;
            step();
            credit_i = 1'b0;
            step();
            step();
        end
        repeat (3) step();
        smp();
        chk("full_fwd8", 64'(n_fwd - base), 8);
        chk("full_lock", 64'(lock_o), 1);
        do_reset();

        // Credit overflow and transfer+credit in one cycle
        credit_i = 1'b1;
        smp();
        chk("ovf_err", 64'(error_o), 1);
        step();
        credit_i = 1'b0;
        smp();
        chk("ovf_err_clr", 64'(error_o), 0);
        grant_i = 1'b1;
        push(HEAD, 1'b1);
        step();
        push(BODY, 1'b1);
        step();
        push(BODY, 1'b1);
        credit_i = 1'b1;
        smp();
        chk("simul_req", 64'(request_o), 1);
        chk("simul_err", 64'(error_o),   0);
        step();
        credit_i = 1'b0;
        push(BODY, 1'b1);
        step();
        push(BODY, 1'b1);
        step();
        push(BODY, 1'b1);
        smp();
        chk("simul_kept2", 64'(request_o), 0);
        grant_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            credit_i = 1'b1;
            smp();
            chk($sformatf("refill%0d_err", k), 64'(error_o), 64'(k == 4));
            step();
            credit_i = 1'b0;
        end
        grant_i = 1'b1;
        push(TAIL, 1'b1);
        repeat (3) step();
        smp();
        chk("refill_unlock", 64'(lock_o), 0);
        do_reset();

        // Reset mid-packet: HEAD forwarded, BODY still buffered
        push(HEAD, 1'b1);
        push(BODY, 1'b0);
        grant_i = 1'b1;
        step();
        grant_i = 1'b0;
        smp();
        chk("mid_lock", 64'(lock_o), 1);
        step();
        rst = 1'b0;
        #1;
        chk("mid_rst_lock",  64'(lock_o),    0);
        chk("mid_rst_ready", 64'(ready_o),   1);
        chk("mid_rst_req",   64'(request_o), 0);
        chk("mid_rst_valid", 64'(valid_o),   0);
        chk("mid_rst_queue", 64'(exp_q.size()), 0);
        step();
        rst     = 1'b1;
        grant_i = 1'b1;
        base    = n_fwd;
        repeat (6) step();
        smp();
        chk("mid_no_valid", 64'(n_fwd - base), 0);
        for (int k = 0; k < 4; k++) begin
            push(HEADTAIL, 1'b1);
            smp();
            chk("mid_credit_req", 64'(request_o), 1);
            step();
        end
        push(HEADTAIL, 1'b1);
        smp();
        chk("mid_credit4", 64'(request_o), 0);
        step();
        credit_i = 1'b1;
        step();
        credit_i = 1'b0;
        repeat (3) step();
        smp();
        chk("final_queue", 64'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/input_request_unit.md
INPUT_REQUEST_UNIT -- requirements
Module: input_request_unit

Interface
REQ-001 SHALL have parameter BUFFER_SIZE, default 8, input flit FIFO depth (power of two, >=2).
REQ-002 SHALL have parameter MAX_CREDITS, default 4, downstream buffer slots available after reset.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, flit payload width.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port data_i  input  flit_t  upstream flit (type + payload).
REQ-007 SHALL have port valid_i  input  1  data_i valid this cycle.
REQ-008 SHALL have port ready_o  output  1  FIFO not full; a flit is accepted when valid_i && ready_o.
REQ-009 SHALL have port request_o  output  1  request to the round-robin arbiter for this agent.
REQ-010 SHALL have port grant_i  input  1  this agent's bit of the arbiter grant vector, same-cycle response to request_o.
REQ-011 SHALL have port lock_o  output  1  packet in progress; the arbiter keeps the grant while high.
REQ-012 SHALL have port credit_i  input  1  one downstream slot freed (one-cycle pulse).
REQ-013 SHALL have port data_o  output  flit_t  flit forwarded downstream.
REQ-014 SHALL have port valid_o  output  1  data_o valid.
REQ-015 SHALL have port error_o  output  1  one-cycle pulse on a protocol violation.

Function
REQ-016 SHALL write data_i into the FIFO tail on valid_i && ready_o; ready_o = !full, independent of a same-cycle pop.
REQ-017 SHALL drive request_o = !empty && credits>0, combinationally from registered state.
REQ-018 SHALL treat a cycle with request_o && grant_i as a transfer: pop FIFO head, register it to data_o, assert valid_o in the next cycle (latency 1), decrement credits.
REQ-019 SHALL ignore grant_i when request_o is low; valid_o SHALL be low in any cycle not following a transfer.
REQ-020 SHALL increment credits on credit_i; transfer and credit_i in the same cycle SHALL leave credits unchanged.
REQ-021 SHALL never let credits exceed MAX_CREDITS; a credit_i at MAX_CREDITS without same-cycle transfer SHALL be dropped and pulse error_o.
REQ-022 SHALL implement FSM IDLE / ACTIVE; lock_o = (state == ACTIVE).
REQ-023 IDLE: transfer of HEAD -> ACTIVE; transfer of HEADTAIL -> stay IDLE.
REQ-024 ACTIVE: transfer of BODY -> stay ACTIVE; transfer of TAIL -> IDLE.
REQ-025 In IDLE, a FIFO head of type BODY or TAIL SHALL be discarded (popped without request, no credit used, valid_o low) with error_o pulsed in that cycle.
REQ-026 In ACTIVE, a transferred HEAD or HEADTAIL SHALL still be forwarded, pulse error_o, and leave state per its type (HEAD -> ACTIVE, HEADTAIL -> IDLE).
REQ-027 Simultaneous push and pop when neither full nor empty SHALL keep occupancy constant; read/write pointers SHALL wrap modulo BUFFER_SIZE.

Reset
REQ-028 On rst low, asynchronously: FIFO empty, pointers 0, credits = MAX_CREDITS, state IDLE, valid_o/error_o/request_o/lock_o 0, data_o 0, ready_o 1.
REQ-029 Reset mid-packet SHALL discard buffered flits and in-flight state; no flit transfer SHALL occur until the first edge after rst returns high.

Structure
REQ-030 flit_type_t (HEAD, BODY, TAIL, HEADTAIL) and flit_t {flit_type_t, payload} SHALL live in shared package noc_params, alongside DATA_WIDTH default.
REQ-031 FIFO storage SHALL be sub-module circular_buffer (push, pop, full, empty, head-of-queue data); FSM, credit counter and handshake logic in input_request_unit.

Verification
REQ-032 Reset, push HEAD,BODY,TAIL, grant_i tied high -> valid_o on 3 consecutive cycles in order, lock_o high from after HEAD until after TAIL, credits 4->1.
REQ-033 MAX_CREDITS=4, push 6-flit packet, no credit_i -> exactly 4 flits forwarded, request_o low with FIFO non-empty; two credit_i pulses -> remaining 2 forwarded.
REQ-034 Push 9 flits back-to-back with grant_i low, BUFFER_SIZE=8 -> ready_o low after 8th accept, 9th not stored; one transfer -> ready_o high next cycle.
REQ-035 Transfer and credit_i in same cycle at credits=2 -> credits stay 2; credit_i at credits=4 -> error_o pulse, credits 4.
REQ-036 FIFO head BODY while IDLE -> flit discarded, error_o one cycle, request_o never asserted for it, credits unchanged.
REQ-037 Assert rst low after HEAD forwarded, BODY buffered -> lock_o 0, ready_o 1, credits 4 immediately; no valid_o afterwards without new pushes.
